// File: rtl/bus_demux14_pkg.sv
// Shared encodings for the bus_demux14 load/store router: FSM states, target IDs
// and the timeout counter width.
package bus_demux14_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_t;

  localparam logic [1:0] TGT_DMEM  = 2'b00;
  localparam logic [1:0] TGT_GPIO  = 2'b01;
  localparam logic [1:0] TGT_TIMER = 2'b10;
  localparam logic [1:0] TGT_UART  = 2'b11;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/mux41_n.sv
// Four-way DLEN-bit selector used to pick the responding target's read data.
module mux41_n #(
  parameter int unsigned DLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [DLEN-1:0] d0,
  input  logic [DLEN-1:0] d1,
  input  logic [DLEN-1:0] d2,
  input  logic [DLEN-1:0] d3,
  output logic [DLEN-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      2'b11:   y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/bus_demux14.sv
// Routes one CPU load/store request to one of four targets selected by the top two
// address bits, waits for that target's ack (or a timeout) and returns a one-cycle response.
module bus_demux14
  import bus_demux14_pkg::*;
#(
  parameter int unsigned DLEN = 32,
  parameter int unsigned ALEN = 32,
  parameter int unsigned TMO  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALEN-1:0]     req_addr,
  input  logic                req_we,
  input  logic [DLEN-1:0]     req_wdata,
  input  logic [DLEN/8-1:0]   req_strb,
  output logic                rsp_valid,
  output logic [DLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic [3:0]          tgt_valid,
  output logic [ALEN-1:0]     tgt_addr,
  output logic                tgt_we,
  output logic [DLEN-1:0]     tgt_wdata,
  output logic [DLEN/8-1:0]   tgt_strb,
  input  logic [3:0]          tgt_ack,
  input  logic [DLEN-1:0]     tgt_rdata00,
  input  logic [DLEN-1:0]     tgt_rdata01,
  input  logic [DLEN-1:0]     tgt_rdata10,
  input  logic [DLEN-1:0]     tgt_rdata11
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TMO - 1);

  state_t            state_q, state_d;
  logic [1:0]        sel_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              latch;
  logic [DLEN-1:0]   sel_rdata;

  mux41_n #(
    .DLEN (DLEN)
  ) u_rdata_mux (
    .sel (sel_q),
    .d0  (tgt_rdata00),
    .d1  (tgt_rdata01),
    .d2  (tgt_rdata10),
    .d3  (tgt_rdata11),
    .y   (sel_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (|req_strb) begin
            latch   = 1'b1;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            // Empty byte mask: answer with an error without touching any target.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StBusy: begin
        // Ack is checked first so it beats a timeout reached in the same cycle.
        if (tgt_ack[sel_q]) begin
          rdata_d = tgt_we ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tgt_addr  <= '0;
      tgt_we    <= 1'b0;
      tgt_wdata <= '0;
      tgt_strb  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        sel_q     <= req_addr[ALEN-1:ALEN-2];
        tgt_addr  <= req_addr;
        tgt_we    <= req_we;
        tgt_wdata <= req_wdata;
        tgt_strb  <= req_strb;
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign tgt_valid = (state_q == StBusy) ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_bus_demux14.sv
// Directed bench for bus_demux14: a vector table of single transactions on a TMO=15 and a
// TMO=4 instance, plus hand-written sequences for reset, stray acks, zero strobe and reset.
module tb_bus_demux14;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [3:0]  tgt_ack;
  logic [31:0] rd00, rd01, rd10, rd11;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_tgt_we;
  logic [31:0] a_rsp_rdata, a_tgt_addr, a_tgt_wdata;
  logic [3:0]  a_tgt_valid, a_tgt_strb;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_tgt_we;
  logic [31:0] b_rsp_rdata, b_tgt_addr, b_tgt_wdata;
  logic [3:0]  b_tgt_valid, b_tgt_strb;

  // Selects which instance the checks observe.
  logic        use_b;
  logic        m_ready, m_rsp_valid, m_rsp_err, m_we;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_tv, m_strb;

  assign m_ready     = use_b ? b_req_ready : a_req_ready;
  assign m_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
  assign m_we        = use_b ? b_tgt_we    : a_tgt_we;
  assign m_rdata     = use_b ? b_rsp_rdata : a_rsp_rdata;
  assign m_addr      = use_b ? b_tgt_addr  : a_tgt_addr;
  assign m_wdata     = use_b ? b_tgt_wdata : a_tgt_wdata;
  assign m_tv        = use_b ? b_tgt_valid : a_tgt_valid;
  assign m_strb      = use_b ? b_tgt_strb  : a_tgt_strb;

  bus_demux14 #(.DLEN(32), .ALEN(32), .TMO(15)) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (a_req_ready), .req_addr (req_addr),
    .req_we (req_we), .req_wdata (req_wdata), .req_strb (req_strb),
    .rsp_valid (a_rsp_valid), .rsp_rdata (a_rsp_rdata), .rsp_err (a_rsp_err),
    .tgt_valid (a_tgt_valid), .tgt_addr (a_tgt_addr), .tgt_we (a_tgt_we),
    .tgt_wdata (a_tgt_wdata), .tgt_strb (a_tgt_strb), .tgt_ack (tgt_ack),
    .tgt_rdata00 (rd00), .tgt_rdata01 (rd01), .tgt_rdata10 (rd10), .tgt_rdata11 (rd11)
  );

  bus_demux14 #(.DLEN(32), .ALEN(32), .TMO(4)) dut4 (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (b_req_ready), .req_addr (req_addr),
    .req_we (req_we), .req_wdata (req_wdata), .req_strb (req_strb),
    .rsp_valid (b_rsp_valid), .rsp_rdata (b_rsp_rdata), .rsp_err (b_rsp_err),
    .tgt_valid (b_tgt_valid), .tgt_addr (b_tgt_addr), .tgt_we (b_tgt_we),
    .tgt_wdata (b_tgt_wdata), .tgt_strb (b_tgt_strb), .tgt_ack (tgt_ack),
    .tgt_rdata00 (rd00), .tgt_rdata01 (rd01), .tgt_rdata10 (rd10), .tgt_rdata11 (rd11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          on_b;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ack_at;     // BUSY cycle (1-based) carrying the ack, 0 = never
    logic [31:0] rdata_in;
    int          exp_busy;
    logic [3:0]  exp_tv;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Selected target sees the requested data; others carry distinct decoys.
  task automatic drive_rdata(input logic [1:0] sel, input logic [31:0] val);
    rd00 = (sel == 2'd0) ? val : 32'hA0A0_0000;
    rd01 = (sel == 2'd1) ? val : 32'hA1A1_1111;
    rd10 = (sel == 2'd2) ? val : 32'hA2A2_2222;
    rd11 = (sel == 2'd3) ? val : 32'hA3A3_3333;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (a_req_ready && b_req_ready) ok = 1'b1;
      else tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int         busy = 0;
    bit         tv_ok = 1'b1;
    bit         done = 1'b0;
    logic [1:0] sel;
    sel   = v.addr[31:30];
    use_b = v.on_b;
    chk({nm, " ready_before"}, 32'(m_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_we    = v.we;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    chk({nm, " tgt_addr"}, m_addr, v.addr);
    chk({nm, " tgt_wdata"}, m_wdata, v.wdata);
    chk({nm, " tgt_we_strb"}, {27'd0, m_we, m_strb}, {27'd0, v.we, v.strb});
    for (int c = 1; c <= 40 && !done; c++) begin
      if (m_rsp_valid) begin
        done = 1'b1;
      end else begin
        busy++;
        if (m_tv !== v.exp_tv) tv_ok = 1'b0;
        drive_rdata(sel, v.rdata_in);
        if (c == v.ack_at) tgt_ack = 4'b0001 << sel;
        tick();
        tgt_ack = 4'b0000;
      end
    end
    chk({nm, " rsp_seen"}, 32'(done), 32'd1);
    chk({nm, " busy_cycles"}, 32'(busy), 32'(v.exp_busy));
    chk({nm, " tgt_valid_ok"}, 32'(tv_ok), 32'd1);
    chk({nm, " rsp_rdata"}, m_rdata, v.exp_rdata);
    chk({nm, " rsp_err"}, 32'(m_rsp_err), 32'(v.exp_err));
    tick();
    chk({nm, " ready_after"}, {30'd0, m_ready, m_rsp_valid}, 32'd2);
    chk({nm, " rdata_held"}, m_rdata, v.exp_rdata);
    wait_idle({nm, " both_idle"});
    use_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; req_strb = '0; tgt_ack = '0; use_b = 1'b0;
    drive_rdata(2'd0, 32'h0);

    //        b     addr          we    wdata          strb   ack  rdata_in       busy tv       rdata          err
    vecs[0] = '{1'b0, 32'h0000_0010, 1'b0, 32'h0,         4'hF, 1,  32'hDEAD_BEEF, 1,  4'b0001, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b0, 32'hC000_0000, 1'b1, 32'h0000_0041, 4'h1, 5,  32'h1234_5678, 5,  4'b1000, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0,         4'hF, 0,  32'h7777_7777, 15, 4'b0100, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h4000_0008, 1'b0, 32'h0,         4'h3, 3,  32'hCAFE_0001, 3,  4'b0010, 32'hCAFE_0001, 1'b0};
    vecs[4] = '{1'b0, 32'h8000_0010, 1'b0, 32'h0,         4'hF, 15, 32'h0BAD_F00D, 15, 4'b0100, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0100, 1'b1, 32'hA5A5_0F0F, 4'hC, 14, 32'h9999_9999, 14, 4'b0001, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0,         4'hF, 4,  32'h5A5A_5A5A, 4,  4'b0100, 32'h5A5A_5A5A, 1'b0};
    vecs[7] = '{1'b1, 32'h4000_0000, 1'b0, 32'h0,         4'hF, 0,  32'h3333_4444, 4,  4'b0010, 32'h0,         1'b1};

    tick(); tick();
    rst_n = 1'b1;
    chk("reset ready", 32'(a_req_ready), 32'd1);
    chk("reset tv_rsp", {27'd0, a_tgt_valid, a_rsp_valid}, 32'd0);
    chk("reset err_rdata", a_rsp_rdata | 32'(a_rsp_err), 32'd0);
    chk("reset buses", a_tgt_addr | a_tgt_wdata | 32'(a_tgt_strb) | 32'(a_tgt_we), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Acks while idle are ignored.
    tgt_ack = 4'hF;
    tick();
    tgt_ack = 4'h0;
    chk("idle_ack no_rsp", {30'd0, a_rsp_valid, a_req_ready}, 32'd1);

    // Stray ack on GPIO while DMEM is selected.
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_we = 1'b0; req_strb = 4'hF;
    tick();
    req_valid = 1'b0;
    drive_rdata(2'd0, 32'h1111_2222);
    tgt_ack = 4'b0010;
    tick();
    chk("stray cyc2", {27'd0, a_tgt_valid, a_rsp_valid}, {27'd0, 4'b0001, 1'b0});
    tick();
    chk("stray cyc3", {27'd0, a_tgt_valid, a_rsp_valid}, {27'd0, 4'b0001, 1'b0});
    tgt_ack = 4'b0001;
    tick();
    tgt_ack = 4'b0000;
    chk("stray rsp", {31'd0, a_rsp_valid}, 32'd1);
    chk("stray rdata", a_rsp_rdata, 32'h1111_2222);
    chk("stray err", 32'(a_rsp_err), 32'd0);
    tick();
    wait_idle("stray idle");

    // Zero byte mask: immediate error response, no target strobe.
    req_valid = 1'b1; req_addr = 32'h4000_0000; req_strb = 4'h0;
    tick();
    req_valid = 1'b0;
    chk("zstrb rsp", {27'd0, a_tgt_valid, a_rsp_valid}, 32'd1);
    chk("zstrb err_rdata", {a_rsp_rdata[30:0], a_rsp_err}, 32'd1);
    tick();
    chk("zstrb after", {26'd0, a_tgt_valid, a_rsp_valid, a_req_ready}, 32'd1);

    // Reset on the third BUSY cycle drops the transaction.
    req_valid = 1'b1; req_addr = 32'h4000_0040; req_strb = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst busy3 tv", 32'(a_tgt_valid), 32'(4'b0010));
    rst_n = 1'b0;
    tick();
    chk("rst tv_rsp", {27'd0, a_tgt_valid, a_rsp_valid}, 32'd0);
    rst_n = 1'b1;
    chk("rst ready", 32'(a_req_ready), 32'd1);
    tick();
    chk("rst no_rsp", {31'd0, a_rsp_valid}, 32'd0);
    run_txn(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
